// File: rtl/jedro_1_lsu_pkg.sv
// Shared LSU definitions for jedro_1: op encoding, FSM states and op classification helpers.
package jedro_1_defines;

  localparam int LSU_CTRL_WIDTH = 4;

  // bit3 = store, bit2 = unsigned, bits[1:0] = size
  localparam logic [LSU_CTRL_WIDTH-1:0] LSU_LB  = 4'b0000;
  localparam logic [LSU_CTRL_WIDTH-1:0] LSU_LH  = 4'b0001;
  localparam logic [LSU_CTRL_WIDTH-1:0] LSU_LW  = 4'b0010;
  localparam logic [LSU_CTRL_WIDTH-1:0] LSU_LBU = 4'b0100;
  localparam logic [LSU_CTRL_WIDTH-1:0] LSU_LHU = 4'b0101;
  localparam logic [LSU_CTRL_WIDTH-1:0] LSU_SB  = 4'b1000;
  localparam logic [LSU_CTRL_WIDTH-1:0] LSU_SH  = 4'b1001;
  localparam logic [LSU_CTRL_WIDTH-1:0] LSU_SW  = 4'b1010;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE    = 2'b00,
    LSU_REQ     = 2'b01,
    LSU_WAIT_RD = 2'b10,
    LSU_WB      = 2'b11
  } lsu_state_e;

  function automatic logic lsu_ctrl_legal(input logic [LSU_CTRL_WIDTH-1:0] ctrl);
    case (ctrl)
      LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW: lsu_ctrl_legal = 1'b1;
      default: lsu_ctrl_legal = 1'b0;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [LSU_CTRL_WIDTH-1:0] ctrl,
                                          input logic [1:0] addr_lo);
    case (ctrl[1:0])
      LSU_SIZE_H: lsu_misaligned = addr_lo[0];
      LSU_SIZE_W: lsu_misaligned = (addr_lo != 2'b00);
      default:    lsu_misaligned = 1'b0;
    endcase
  endfunction

  // Drop the sub-size address bits so halfwords and words land on their natural boundary.
  function automatic logic [31:0] lsu_force_align(input logic [LSU_CTRL_WIDTH-1:0] ctrl,
                                                  input logic [31:0] addr);
    case (ctrl[1:0])
      LSU_SIZE_H: lsu_force_align = {addr[31:1], 1'b0};
      LSU_SIZE_W: lsu_force_align = {addr[31:2], 2'b00};
      default:    lsu_force_align = addr;
    endcase
  endfunction

endpackage

// File: rtl/jedro_1_lsu_align.sv
// Byte-lane steering for jedro_1 LSU: store byte enables/lane replication and load extraction/extension.
module jedro_1_lsu_align
  import jedro_1_defines::*;
(
  input  logic [LSU_CTRL_WIDTH-1:0] ctrl,
  input  logic [1:0]                addr_lo,
  input  logic [31:0]               store_data,
  input  logic [31:0]               load_word,
  output logic [3:0]                byte_en,
  output logic [31:0]               lane_data,
  output logic [31:0]               load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = load_word[{addr_lo, 3'b000} +: 8];
  assign half_s = addr_lo[1] ? load_word[31:16] : load_word[15:0];

  // Store side: byte enables and replicated lane data
  always_comb begin
    byte_en   = 4'b0000;
    lane_data = store_data;
    if (ctrl[3]) begin
      case (ctrl[1:0])
        LSU_SIZE_B: begin
          byte_en   = 4'b0001 << addr_lo;
          lane_data = {4{store_data[7:0]}};
        end
        LSU_SIZE_H: begin
          byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
          lane_data = {2{store_data[15:0]}};
        end
        LSU_SIZE_W: byte_en = 4'b1111;
        default:    byte_en = 4'b0000;
      endcase
    end else begin
      byte_en = 4'b0000;
    end
  end

  // Load side: select lane then sign- or zero-extend
  always_comb begin
    load_data = load_word;
    case (ctrl[1:0])
      LSU_SIZE_B: load_data = ctrl[2] ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
      LSU_SIZE_H: load_data = ctrl[2] ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      LSU_SIZE_W: load_data = load_word;
      default:    load_data = load_word;
    endcase
  end

endmodule

// File: rtl/jedro_1_lsu.sv
// jedro_1 load-store unit: one data-RAM transaction at a time over req/gnt/rvalid.
// Optional macro LSU_MISALIGN_EXC_EN: reject misaligned accesses instead of forcing alignment.
module jedro_1_lsu
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ctrl_valid_i,
  output logic                      ctrl_ready_o,
  input  logic [LSU_CTRL_WIDTH-1:0] ctrl_i,
  input  logic [DATA_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0] regdest_i,
  output logic                      ram_req_o,
  input  logic                      ram_gnt_i,
  output logic [3:0]                ram_we_o,
  output logic [DATA_WIDTH-1:0]     ram_addr_o,
  output logic [DATA_WIDTH-1:0]     ram_wdata_o,
  input  logic                      ram_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     ram_rdata_i,
  output logic                      wb_valid_o,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0]     wb_data_o,
  output logic                      misaligned_o,
  output logic                      busy_o
);

  lsu_state_e                state_r;
  logic [LSU_CTRL_WIDTH-1:0] ctrl_r;
  logic [1:0]                addr_lo_r;
  logic [REG_ADDR_WIDTH-1:0] regdest_r;
  logic                      misaligned_r;

  logic                      accept_s;
  logic                      misalign_s;
  logic [DATA_WIDTH-1:0]     eff_addr_s;
  logic [LSU_CTRL_WIDTH-1:0] align_ctrl_s;
  logic [1:0]                align_addr_s;
  logic [3:0]                byte_en_s;
  logic [DATA_WIDTH-1:0]     lane_data_s;
  logic [DATA_WIDTH-1:0]     load_data_s;

  assign accept_s   = ctrl_valid_i && (state_r == LSU_IDLE) && lsu_ctrl_legal(ctrl_i);
  assign eff_addr_s = lsu_force_align(ctrl_i, addr_i);
`ifdef LSU_MISALIGN_EXC_EN
  assign misalign_s = lsu_misaligned(ctrl_i, addr_i[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  // In IDLE the aligner sees the incoming op (store lanes); afterwards the captured op (load extract).
  assign align_ctrl_s = (state_r == LSU_IDLE) ? ctrl_i : ctrl_r;
  assign align_addr_s = (state_r == LSU_IDLE) ? eff_addr_s[1:0] : addr_lo_r;

  jedro_1_lsu_align u_align (
    .ctrl       (align_ctrl_s),
    .addr_lo    (align_addr_s),
    .store_data (wdata_i),
    .load_word  (ram_rdata_i),
    .byte_en    (byte_en_s),
    .lane_data  (lane_data_s),
    .load_data  (load_data_s)
  );

  assign ctrl_ready_o = (state_r == LSU_IDLE);
  assign busy_o       = (state_r != LSU_IDLE);
  assign misaligned_o = misaligned_r;

  // Transaction FSM with registered bus and writeback outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= LSU_IDLE;
      ctrl_r       <= 4'b0000;
      addr_lo_r    <= 2'b00;
      regdest_r    <= '0;
      misaligned_r <= 1'b0;
      ram_req_o    <= 1'b0;
      ram_we_o     <= 4'b0000;
      ram_addr_o   <= '0;
      ram_wdata_o  <= '0;
      wb_valid_o   <= 1'b0;
      wb_addr_o    <= '0;
      wb_data_o    <= '0;
    end else begin
      wb_valid_o   <= 1'b0;
      misaligned_r <= 1'b0;
      case (state_r)
        LSU_IDLE: begin
          if (accept_s) begin
            if (misalign_s) begin
              misaligned_r <= 1'b1;
            end else begin
              ctrl_r      <= ctrl_i;
              addr_lo_r   <= eff_addr_s[1:0];
              regdest_r   <= regdest_i;
              ram_req_o   <= 1'b1;
              ram_we_o    <= byte_en_s;
              ram_addr_o  <= {eff_addr_s[DATA_WIDTH-1:2], 2'b00};
              ram_wdata_o <= lane_data_s;
              state_r     <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          if (ram_gnt_i) begin
            ram_req_o <= 1'b0;
            ram_we_o  <= 4'b0000;
            state_r   <= ctrl_r[3] ? LSU_IDLE : LSU_WAIT_RD;
          end
        end
        LSU_WAIT_RD: begin
          if (ram_rvalid_i) begin
            wb_data_o  <= load_data_s;
            wb_addr_o  <= regdest_r;
            wb_valid_o <= (regdest_r != '0);
            state_r    <= LSU_WB;
          end
        end
        LSU_WB:  state_r <= LSU_IDLE;
        default: state_r <= LSU_IDLE;
      endcase
    end
  end

endmodule
